fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage of the Redux-V core. Owns the program counter, drives
//  the address of the combinational instruction_memory, and latches the
//  returned byte into a one-entry instruction register (IR).
//  Hands the IR to the decoder through a valid/ready handshake.
//  Accepts redirects (jump/branch target) from execute, and supports halt/resume.
// PARAMETERS
//  ADDR_W    8   PC / instruction-memory address width
//  INSTR_W   8   instruction width
//  RESET_PC  0   PC value loaded on reset
//  WRAP_EN   1   1: PC wraps 2^ADDR_W-1 -> 0; 0: fetch stops after last address (END)
//  CNT_W     16  width of retired-fetch counter
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        synchronous, active-low reset
//  imem_addr    out  ADDR_W   address to instruction_memory (= PC, combinational)
//  imem_data    in   INSTR_W  instruction from instruction_memory, same cycle
//  ir_instr     out  INSTR_W  registered instruction offered to decoder
//  ir_pc        out  ADDR_W   address ir_instr was fetched from
//  ir_valid     out  1        IR holds an instruction
//  ir_ready     in   1        decoder accepts IR this cycle
//  redirect_en  in   1        load PC from redirect_pc; flush IR
//  redirect_pc  in   ADDR_W   redirect target
//  halt_req     in   1        stop fetching
//  resume       in   1        restart fetching from HALT
//  halted       out  1        state is HALT or END
//  fetch_count  out  CNT_W    number of IR loads since reset, saturating
// BEHAVIOUR
//  Reset (rst_n=0 at edge): pc=RESET_PC, ir_valid=0, ir_instr=0, ir_pc=0,
//   state=RUN, fetch_count=0, halted=0. Reset wins over every other input.
//  imem_addr = pc at all times (no latency); data sampled the same cycle.
//  load = (state==RUN) && (!ir_valid || ir_ready) && !redirect_en.
//  On load: ir_instr<=imem_data, ir_pc<=pc, ir_valid<=1, pc<=pc+1 (mod 2^ADDR_W),
//   fetch_count<=fetch_count+1 unless all-ones. Throughput 1 instr/cycle.
//  ir_ready && ir_valid && !load -> ir_valid<=0. ir_valid && !ir_ready -> IR held
//   stable, pc unchanged.
//  redirect_en (any state): pc<=redirect_pc, ir_valid<=0 at same edge. It overrides
//   load and halt_req that cycle. The first instruction from the target is in IR one
//   cycle later. From END, redirect -> RUN. From HALT, redirect keeps HALT.
//  FSM states: RUN, HALT, END.
//   RUN->HALT: halt_req=1 (no load that cycle). The current IR is still offered and
//    may drain.
//   HALT->RUN: resume=1 and halt_req=0. If both are 1, stay in HALT.
//   RUN->END: WRAP_EN=0 and load with pc==2^ADDR_W-1. pc stays at that value.
//   END->RUN: only via redirect_en. halt_req in END -> HALT.
//  halted = (state!=RUN), registered with the state.
//  Boundaries:
//   WRAP_EN=1 and pc==255 -> next pc 0, with no bubble.
//   Decoder stall during a redirect: the IR is still flushed.
//   Reset mid-stall: the IR is dropped.
// STRUCTURE
//  redux_pkg: ADDR_W/INSTR_W defaults, RESET_PC, fetch_state_t {RUN,HALT,END}.
//  Sub-module sat_counter #(CNT_W) (inc, clear) provides fetch_count.
//  Everything else (PC, IR, FSM) is inline.
// TESTING (bench instantiates instruction_memory ALG=1 on imem_addr/imem_data)
//  1 Reset, then ir_ready=1 held -> ir_pc 0,1,2,3 on consecutive cycles;
//    ir_instr B0,B5,BA,BF; fetch_count=4.
//  2 Hold ir_ready=0 for 3 cycles after the first load -> ir_instr=B0 and ir_pc=0
//    stable, imem_addr=1. Release -> ir_pc 1 on the next edge.
//  3 redirect_en with redirect_pc=0x15 while ir_valid=1 -> ir_valid=0 next cycle,
//    then ir_pc=0x15, ir_instr=E1.
//  4 Redirect to 0xFE, WRAP_EN=1 -> ir_pc FE,FF,00,01. With WRAP_EN=0 -> FE,FF,
//    then halted=1 and no further loads. Redirect to 0 -> RUN.
//  5 halt_req pulse at ir_pc=5 -> halted=1, IR drains, fetch_count frozen. resume
//    -> next ir_pc=6. Assert halt_req and resume together -> stays HALT.
//  6 rst_n=0 for 1 cycle mid-stream with ir_ready=0 -> ir_valid=0, pc=0,
//    fetch_count=0 next cycle; the sequence restarts from B0.

Source files
------------

// File: rtl/redux_pkg.sv
// ============================================================================
//  Module      : redux_pkg
//  Description : Shared defaults and the fetch-stage state type for the
//                Redux-V core.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package redux_pkg;

    localparam int ADDR_W_DEF   = 8;
    localparam int INSTR_W_DEF  = 8;
    localparam int RESET_PC_DEF = 0;
    localparam int CNT_W_DEF    = 16;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        END  = 2'd2
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones; synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear first, otherwise increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
//  Module      : fetch_unit
//  Description : Redux-V instruction-fetch stage. Owns the PC, reads the
//                combinational instruction memory, and offers a one-entry
//                instruction register to the decoder via valid/ready.
//                Supports redirects and halt/resume.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import redux_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int INSTR_W  = INSTR_W_DEF,
    parameter int RESET_PC = RESET_PC_DEF,
    parameter bit WRAP_EN  = 1'b1,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] ir_instr,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               redirect_en,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt_req,
    input  logic               resume,
    output logic               halted,
    output logic [CNT_W-1:0]   fetch_count
);

    localparam logic [ADDR_W-1:0] PC_LAST  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_instr_q, ir_instr_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic               ir_valid_q, ir_valid_d;
    logic               load;
    logic               at_last;

    // A halt request also blocks the load so the stage stops on that edge.
    assign load    = (state_q == RUN) && (!ir_valid_q || ir_ready)
                     && !redirect_en && !halt_req;
    assign at_last = (pc_q == PC_LAST);

    // Next-state logic; a redirect takes priority over halt/resume.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (!redirect_en) begin
                    if (halt_req) begin
                        state_d = HALT;
                    end else if (load && !WRAP_EN && at_last) begin
                        state_d = END;
                    end
                end
            end
            HALT: begin
                if (!redirect_en && resume && !halt_req) begin
                    state_d = RUN;
                end
            end
            END: begin
                if (redirect_en) begin
                    state_d = RUN;
                end else if (halt_req) begin
                    state_d = HALT;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // PC and instruction-register update: redirect flushes, load fills,
    // a decoder handshake without a refill empties the IR.
    always_comb begin
        pc_d       = pc_q;
        ir_instr_d = ir_instr_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        if (redirect_en) begin
            pc_d       = redirect_pc;
            ir_valid_d = 1'b0;
        end else if (load) begin
            ir_instr_d = imem_data;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            // Without wrap the PC parks on the last address once it is fetched.
            if (WRAP_EN || !at_last) begin
                pc_d = pc_q + 1'b1;
            end
        end else if (ir_valid_q && ir_ready) begin
            ir_valid_d = 1'b0;
        end
    end

    // State, PC and IR registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= PC_RESET;
            ir_instr_q <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_instr_q <= ir_instr_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_fetch_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (load),
        .clear_i (1'b0),
        .count_o (fetch_count)
    );

    assign imem_addr = pc_q;
    assign ir_instr  = ir_instr_q;
    assign ir_pc     = ir_pc_q;
    assign ir_valid  = ir_valid_q;
    assign halted    = (state_q != RUN);

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. Two instances share the
//                stimulus: one with PC wrap, one that stops at the last
//                address. Decoder handshakes on the wrapping instance are
//                checked against a queue of expected (pc, instr) pairs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        ir_ready;
    logic        redirect_en;
    logic [7:0]  redirect_pc;
    logic        halt_req;
    logic        resume;

    logic [7:0]  imem_addr1, imem_data1, ir_instr1, ir_pc1;
    logic        ir_valid1, halted1;
    logic [15:0] fetch_count1;

    logic [7:0]  imem_addr0, imem_data0, ir_instr0, ir_pc0;
    logic        ir_valid0, halted0;
    logic [15:0] fetch_count0;

    int          n_checks;
    int          n_fail;
    logic [15:0] sb_q[$];

    // Program image: B0 + 5*addr, except one recognisable jump target.
    function automatic logic [7:0] img(input logic [7:0] a);
        logic [7:0] v;
        v = 8'hB0 + 8'(a * 8'd5);
        if (a == 8'h15) v = 8'hE1;
        return v;
    endfunction

    assign imem_data1 = img(imem_addr1);
    assign imem_data0 = img(imem_addr0);

    fetch_unit #(
        .ADDR_W (8), .INSTR_W (8), .RESET_PC (0), .WRAP_EN (1'b1), .CNT_W (16)
    ) dut_wrap (
        .clk (clk), .rst_n (rst_n),
        .imem_addr (imem_addr1), .imem_data (imem_data1),
        .ir_instr (ir_instr1), .ir_pc (ir_pc1), .ir_valid (ir_valid1),
        .ir_ready (ir_ready),
        .redirect_en (redirect_en), .redirect_pc (redirect_pc),
        .halt_req (halt_req), .resume (resume),
        .halted (halted1), .fetch_count (fetch_count1)
    );

    fetch_unit #(
        .ADDR_W (8), .INSTR_W (8), .RESET_PC (0), .WRAP_EN (1'b0), .CNT_W (16)
    ) dut_nowrap (
        .clk (clk), .rst_n (rst_n),
        .imem_addr (imem_addr0), .imem_data (imem_data0),
        .ir_instr (ir_instr0), .ir_pc (ir_pc0), .ir_valid (ir_valid0),
        .ir_ready (ir_ready),
        .redirect_en (redirect_en), .redirect_pc (redirect_pc),
        .halt_req (halt_req), .resume (resume),
        .halted (halted0), .fetch_count (fetch_count0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] pc);
        sb_q.push_back({pc, img(pc)});
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        ir_ready    = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 8'h00;
        halt_req    = 1'b0;
        resume      = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Handshake monitor: inputs only change just after posedge, so the
    // value seen here is the one present at the next active edge.
    always @(negedge clk) begin
        if (rst_n && !redirect_en && ir_valid1 && ir_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_pc", {24'd0, ir_pc1}, 32'hFFFF_FFFF);
            end else begin
                logic [15:0] e;
                e = sb_q.pop_front();
                check_eq("sb_pc", {24'd0, ir_pc1}, {24'd0, e[15:8]});
                check_eq("sb_instr", {24'd0, ir_instr1}, {24'd0, e[7:0]});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset state
        rst_n = 1'b0; ir_ready = 1'b0; redirect_en = 1'b0; redirect_pc = 8'h00;
        halt_req = 1'b0; resume = 1'b0;
        tick(); tick();
        check_eq("rst_valid", {31'd0, ir_valid1}, 32'd0);
        check_eq("rst_instr", {24'd0, ir_instr1}, 32'd0);
        check_eq("rst_irpc", {24'd0, ir_pc1}, 32'd0);
        check_eq("rst_addr", {24'd0, imem_addr1}, 32'd0);
        check_eq("rst_halted", {31'd0, halted1}, 32'd0);
        check_eq("rst_count", {16'd0, fetch_count1}, 32'd0);

        // 1: streaming at one instruction per cycle
        sb_q.push_back({8'h00, 8'hB0});
        sb_q.push_back({8'h01, 8'hB5});
        sb_q.push_back({8'h02, 8'hBA});
        sb_q.push_back({8'h03, 8'hBF});
        rst_n = 1'b1; ir_ready = 1'b1;
        repeat (4) tick();
        check_eq("t1_count", {16'd0, fetch_count1}, 32'd4);
        check_eq("t1_irpc", {24'd0, ir_pc1}, 32'h03);
        tick();
        ir_ready = 1'b0;
        check_eq("t1_sb_left", sb_q.size(), 32'd0);

        // 2: decoder stall holds the IR and the PC
        do_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t2_hold_pc", {24'd0, ir_pc1}, 32'h00);
            check_eq("t2_hold_instr", {24'd0, ir_instr1}, 32'hB0);
            check_eq("t2_hold_addr", {24'd0, imem_addr1}, 32'h01);
        end
        push(8'h00);
        ir_ready = 1'b1;
        tick();
        check_eq("t2_release_pc", {24'd0, ir_pc1}, 32'h01);
        ir_ready = 1'b0;

        // 3: redirect while IR valid and decoder stalled
        do_reset();
        ir_ready = 1'b1;
        tick();
        redirect_en = 1'b1; redirect_pc = 8'h15; ir_ready = 1'b0;
        tick();
        check_eq("t3_flush", {31'd0, ir_valid1}, 32'd0);
        check_eq("t3_addr", {24'd0, imem_addr1}, 32'h15);
        redirect_en = 1'b0; ir_ready = 1'b1;
        push(8'h15);
        tick();
        check_eq("t3_pc", {24'd0, ir_pc1}, 32'h15);
        check_eq("t3_instr", {24'd0, ir_instr1}, 32'hE1);
        tick();
        ir_ready = 1'b0;

        // 4: top of address space, with and without wrap
        do_reset();
        tick();
        redirect_en = 1'b1; redirect_pc = 8'hFE;
        tick();
        redirect_en = 1'b0; ir_ready = 1'b1;
        push(8'hFE); push(8'hFF); push(8'h00); push(8'h01);
        tick(); tick();
        check_eq("t4_end_halted", {31'd0, halted0}, 32'd1);
        check_eq("t4_end_pc", {24'd0, ir_pc0}, 32'hFF);
        check_eq("t4_wrap_halted", {31'd0, halted1}, 32'd0);
        tick();
        check_eq("t4_end_drained", {31'd0, ir_valid0}, 32'd0);
        check_eq("t4_wrap_pc", {24'd0, ir_pc1}, 32'h00);
        tick(); tick();
        ir_ready = 1'b0;
        check_eq("t4_end_count", {16'd0, fetch_count0}, 32'd3);
        check_eq("t4_end_addr", {24'd0, imem_addr0}, 32'hFF);
        check_eq("t4_end_still", {31'd0, halted0}, 32'd1);
        redirect_en = 1'b1; redirect_pc = 8'h00;
        tick();
        redirect_en = 1'b0;
        check_eq("t4_end_redirect_run", {31'd0, halted0}, 32'd0);
        check_eq("t4_sb_left", sb_q.size(), 32'd0);

        // 5: halt, drain, resume, and halt+resume together
        do_reset();
        ir_ready = 1'b1;
        for (int i = 0; i < 6; i++) push(8'(i));
        repeat (6) tick();
        check_eq("t5_pc5", {24'd0, ir_pc1}, 32'h05);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check_eq("t5_halted", {31'd0, halted1}, 32'd1);
        tick();
        check_eq("t5_drained", {31'd0, ir_valid1}, 32'd0);
        check_eq("t5_count_frozen", {16'd0, fetch_count1}, 32'd6);
        tick();
        check_eq("t5_count_frozen2", {16'd0, fetch_count1}, 32'd6);
        resume = 1'b1;
        push(8'h06);
        tick();
        resume = 1'b0;
        check_eq("t5_resumed", {31'd0, halted1}, 32'd0);
        tick();
        check_eq("t5_pc6", {24'd0, ir_pc1}, 32'h06);
        check_eq("t5_count7", {16'd0, fetch_count1}, 32'd7);
        halt_req = 1'b1;
        tick();
        check_eq("t5_halted2", {31'd0, halted1}, 32'd1);
        resume = 1'b1;
        tick();
        halt_req = 1'b0; resume = 1'b0; ir_ready = 1'b0;
        check_eq("t5_both_stay", {31'd0, halted1}, 32'd1);
        check_eq("t5_count_end", {16'd0, fetch_count1}, 32'd7);

        // 6: reset in the middle of a decoder stall
        do_reset();
        ir_ready = 1'b1;
        push(8'h00);
        tick(); tick();
        ir_ready = 1'b0;
        tick(); tick();
        check_eq("t6_stall_pc", {24'd0, ir_pc1}, 32'h01);
        check_eq("t6_stall_valid", {31'd0, ir_valid1}, 32'd1);
        rst_n = 1'b0;
        tick();
        check_eq("t6_rst_valid", {31'd0, ir_valid1}, 32'd0);
        check_eq("t6_rst_addr", {24'd0, imem_addr1}, 32'd0);
        check_eq("t6_rst_count", {16'd0, fetch_count1}, 32'd0);
        rst_n = 1'b1; ir_ready = 1'b1;
        push(8'h00); push(8'h01);
        tick();
        check_eq("t6_restart_instr", {24'd0, ir_instr1}, 32'hB0);
        tick(); tick();
        ir_ready = 1'b0;
        tick();
        check_eq("final_sb_left", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
